writeback_stage: RTL and testbench



---
 rtl/writeback_stage.sv | 97 +++++++++
 tb/tb_writeback_stage.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// writeback_stage: final MIPS stage; waits for load data, extends it and drives the register-file write port.
// Optional WB_RETIRE_CNT_EN adds retire_count, a count of COMMIT cycles.
module writeback_stage #(
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 5,
    parameter bit ZERO_REG_WR = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_reg_write,
    input  logic [REG_AW-1:0] in_wr_reg,
    input  logic              in_is_load,
    input  logic [1:0]        in_load_size,
    input  logic              in_load_unsigned,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_reg_write,
    output logic [REG_AW-1:0] wb_wr_reg,
    output logic [DATA_W-1:0] wb_wr_data,
`ifdef WB_RETIRE_CNT_EN
    output logic [31:0]       retire_count,
`endif
    output logic              wb_busy
);
    typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT} state_t;
    state_t state, state_d;
    logic              accept;
    logic [REG_AW-1:0] pend_reg, wr_reg_q;
    logic              pend_rw, pend_uns, commit_rw;
    logic [1:0]        pend_size, pend_lane;
    logic [DATA_W-1:0] data_q, ld_data;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    assign accept       = in_valid && in_ready;
    assign in_ready     = state != WAIT_MEM;
    assign wb_busy      = state == WAIT_MEM;
    assign wb_wr_reg    = wr_reg_q;
    assign wb_wr_data   = data_q;
    assign wb_reg_write = state == COMMIT && commit_rw && (wr_reg_q != '0 || ZERO_REG_WR);
    // Lane select is little-endian; half loads ignore addr[0].
    assign ld_byte = mem_rdata[{pend_lane, 3'b000} +: 8];
    assign ld_half = pend_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    assign ld_data = pend_size == 2'b00 ? {{(DATA_W-8){ld_byte[7] & ~pend_uns}}, ld_byte} :
                     pend_size == 2'b01 ? {{(DATA_W-16){ld_half[15] & ~pend_uns}}, ld_half} :
                     mem_rdata;
    always_comb begin
        state_d = IDLE;
        if (state == WAIT_MEM)
            state_d = mem_rvalid ? COMMIT : WAIT_MEM;
        else if (accept)
            state_d = in_is_load ? WAIT_MEM : COMMIT;
    end
    // Pending load fields live apart from the output registers so wb_wr_* hold during the wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_reg_q  <= '0;
            data_q    <= '0;
            commit_rw <= 1'b0;
            pend_reg  <= '0;
            pend_rw   <= 1'b0;
            pend_uns  <= 1'b0;
            pend_size <= 2'b00;
            pend_lane <= 2'b00;
        end else begin
            state <= state_d;
            if (accept && !in_is_load) begin
                wr_reg_q  <= in_wr_reg;
                data_q    <= in_alu_result;
                commit_rw <= in_reg_write;
            end
            if (accept && in_is_load) begin
                pend_reg  <= in_wr_reg;
                pend_rw   <= in_reg_write;
                pend_uns  <= in_load_unsigned;
                pend_size <= in_load_size;
                pend_lane <= in_alu_result[1:0];
            end
            if (state == WAIT_MEM && mem_rvalid) begin
                wr_reg_q  <= pend_reg;
                data_q    <= ld_data;
                commit_rw <= pend_rw;
            end
        end
    end
`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retire_count <= '0;
        else if (state == COMMIT)
            retire_count <= retire_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed and random checks of writeback_stage against a behavioural model,
// run on two instances that differ only in ZERO_REG_WR.
module tb_writeback_stage;
    logic        clk = 0, rst_n = 0;
    logic        in_valid = 0, in_reg_write = 0, in_is_load = 0, in_load_unsigned = 0, mem_rvalid = 0;
    logic [4:0]  in_wr_reg = '0;
    logic [1:0]  in_load_size = '0;
    logic [31:0] in_alu_result = '0, mem_rdata = '0;
    logic        ready0, we0, busy0, ready1, we1, busy1;
    logic [4:0]  reg0, reg1;
    logic [31:0] data0, data1;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] cnt0, cnt1;
`endif
    int tests = 0, fails = 0;
    logic [4:0]  e_reg = '0;
    logic [31:0] e_data = '0;
    logic [31:0] e_cnt = '0;

    writeback_stage #(.ZERO_REG_WR(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready0),
        .in_reg_write(in_reg_write), .in_wr_reg(in_wr_reg), .in_is_load(in_is_load),
        .in_load_size(in_load_size), .in_load_unsigned(in_load_unsigned),
        .in_alu_result(in_alu_result), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_reg_write(we0), .wb_wr_reg(reg0), .wb_wr_data(data0),
`ifdef WB_RETIRE_CNT_EN
        .retire_count(cnt0),
`endif
        .wb_busy(busy0));

    writeback_stage #(.ZERO_REG_WR(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready1),
        .in_reg_write(in_reg_write), .in_wr_reg(in_wr_reg), .in_is_load(in_is_load),
        .in_load_size(in_load_size), .in_load_unsigned(in_load_unsigned),
        .in_alu_result(in_alu_result), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_reg_write(we1), .wb_wr_reg(reg1), .wb_wr_data(data1),
`ifdef WB_RETIRE_CNT_EN
        .retire_count(cnt1),
`endif
        .wb_busy(busy1));

    always #5 clk = ~clk;

    // Reference load extension: pick the lane arithmetically, then sign-extend by modular subtraction.
    function automatic logic [31:0] ext(input logic [31:0] w, input logic [31:0] addr,
                                        input logic [1:0] sz, input bit u);
        int unsigned v, bits, a;
        a = addr % 4;
        if (sz == 2'd0) begin v = (w >> (8 * a)) % 256; bits = 8; end
        else if (sz == 2'd1) begin v = (w >> (a >= 2 ? 16 : 0)) % 65536; bits = 16; end
        else return w;
        if (!u && v >= (32'd1 << (bits - 1))) v = v - (32'd1 << bits);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input bit we0_e, input bit we1_e, input bit busy_e);
        chk({tag, ".we0"}, {31'd0, we0}, {31'd0, we0_e});
        chk({tag, ".we1"}, {31'd0, we1}, {31'd0, we1_e});
        chk({tag, ".reg0"}, {27'd0, reg0}, {27'd0, e_reg});
        chk({tag, ".reg1"}, {27'd0, reg1}, {27'd0, e_reg});
        chk({tag, ".data0"}, data0, e_data);
        chk({tag, ".data1"}, data1, e_data);
        chk({tag, ".busy"}, {30'd0, busy0, busy1}, {30'd0, busy_e, busy_e});
        chk({tag, ".ready"}, {30'd0, ready0, ready1}, {30'd0, !busy_e, !busy_e});
`ifdef WB_RETIRE_CNT_EN
        chk({tag, ".cnt0"}, cnt0, e_cnt);
        chk({tag, ".cnt1"}, cnt1, e_cnt);
`endif
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [4:0] r, input logic [31:0] d, input bit rw);
        in_valid = 1; in_is_load = 0; in_wr_reg = r; in_alu_result = d; in_reg_write = rw;
        tick;
        in_valid = 0;
        e_reg = r; e_data = d; e_cnt++;
        chk_out("alu", rw && r != 0, rw, 0);
    endtask

    task automatic idle(input string tag);
        tick;
        chk_out(tag, 0, 0, 0);
    endtask

    task automatic load(input logic [4:0] r, input logic [31:0] addr, input logic [1:0] sz,
                        input bit u, input bit rw, input logic [31:0] rdata, input int dly);
        in_valid = 1; in_is_load = 1; in_wr_reg = r; in_alu_result = addr;
        in_load_size = sz; in_load_unsigned = u; in_reg_write = rw;
        tick;
        // Offer a different instruction during the wait; it must not be taken.
        in_is_load = 0; in_wr_reg = 5'($urandom); in_alu_result = $urandom;
        in_load_size = 2'($urandom); in_load_unsigned = 1'($urandom);
        chk_out("ld_wait", 0, 0, 1);
        for (int i = 0; i < dly; i++) begin
            mem_rdata = $urandom;
            tick;
            chk_out("ld_wait", 0, 0, 1);
        end
        mem_rvalid = 1; mem_rdata = rdata;
        tick;
        mem_rvalid = 0; in_valid = 0;
        e_reg = r; e_data = ext(rdata, addr, sz, u); e_cnt++;
        chk_out("ld_commit", rw && r != 0, rw, 0);
    endtask

    initial begin
        tick;
        tick;
        chk_out("reset", 0, 0, 0);
        rst_n = 1;
        idle("idle");
        alu(5'd8, 32'h0000_1234, 1);
        idle("alu_after");
        load(5'd9, 32'h0000_1003, 2'b00, 0, 1, 32'h80FF_FF12, 3);
        load(5'd9, 32'h0000_1003, 2'b00, 1, 1, 32'h80FF_FF12, 3);
        chk("ext_sb", e_data, 32'h0000_0080);
        load(5'd10, 32'h0000_2002, 2'b01, 0, 1, 32'h1234_8001, 0);
        load(5'd10, 32'h0000_2000, 2'b01, 0, 1, 32'h1234_8001, 1);
        load(5'd10, 32'h0000_2001, 2'b01, 0, 1, 32'h1234_8001, 2);
        load(5'd11, 32'h0000_3001, 2'b10, 0, 1, 32'hCAFE_F00D, 1);
        load(5'd12, 32'h0000_3001, 2'b11, 1, 0, 32'h8765_4321, 1);
        idle("idle2");
        alu(5'd0, 32'hDEAD_BEEF, 1);
        idle("zero_after");
        e_cnt = 0;
        rst_n = 0;
        #1;
        e_reg = '0; e_data = '0;
        chk_out("rst_clr", 0, 0, 0);
        rst_n = 1;
        for (int i = 1; i <= 4; i++) alu(5'(i), 32'h100 + 32'(i), 1);
        idle("b2b_after");
        load(5'd13, 32'h0000_4001, 2'b00, 0, 1, 32'h00A5_7F00, 0);
        mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF;
        tick;
        mem_rvalid = 0;
        chk_out("stray_rvalid", 0, 0, 0);
        in_valid = 1; in_is_load = 1; in_wr_reg = 5'd14; in_alu_result = 32'h0;
        in_load_size = 2'b10; in_reg_write = 1;
        tick;
        in_valid = 0;
        chk_out("ld_pre_rst", 0, 0, 1);
        rst_n = 0;
        #1;
        e_reg = '0; e_data = '0; e_cnt = 0;
        chk_out("rst_mid_load", 0, 0, 0);
        tick;
        rst_n = 1;
        mem_rvalid = 1; mem_rdata = 32'h1111_2222;
        tick;
        mem_rvalid = 0;
        chk_out("rst_late_rvalid", 0, 0, 0);
        idle("rst_late_idle");
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0, 1: alu(5'($urandom), $urandom, 1'($urandom));
                2: load(5'($urandom), $urandom, 2'($urandom), 1'($urandom), 1'($urandom),
                        $urandom, int'($urandom_range(0, 3)));
                default: begin
                    mem_rvalid = 1'($urandom); mem_rdata = $urandom;
                    tick;
                    mem_rvalid = 0;
                    chk_out("rnd_idle", 0, 0, 0);
                end
            endcase
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
